// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t      : receiver FSM state encoding
//   DEFAULT_*       : default clock frequency and baud rate
//   uart_timing_t   : clocks-per-bit (C) and clocks-per-half-bit (H)
//   calc_timing()   : derives C = clk/baud and H = C/2 using integer division
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE   = 9600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    typedef struct packed {
        logic [31:0] bit_cycles;
        logic [31:0] half_cycles;
    } uart_timing_t;

    // Clocks per bit and per half bit; both truncate, so the half-bit
    // point lands at or just before the true centre of the start bit.
    function automatic uart_timing_t calc_timing(input int unsigned clk_freq_hz,
                                                 input int unsigned baud_rate);
        uart_timing_t t;
        t.bit_cycles  = clk_freq_hz / baud_rate;
        t.half_cycles = t.bit_cycles / 2;
        return t;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk       : sampling clock (rising edge)
//   rst       : synchronous active-high reset, loads RESET_VALUE into both flops
//   async_in  : asynchronous input level
//   sync_out  : synchronized level, two clocks behind async_in
// RESET_VALUE should match the idle level of the line so that leaving reset
// never looks like an edge.
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Plain two-stage shift; the first stage may go metastable and is given
    // a full clock period to settle before the second stage samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= RESET_VALUE;
            sync_out <= RESET_VALUE;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, with a one-entry valid/ready output holding
// register. The line keeps being received regardless of the consumer; a byte
// that completes while the holding register is still full is dropped and
// flagged with an overrun pulse.
// Ports:
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   rx_serial  : asynchronous serial line, idle high
//   rx_data    : received byte, stable while rx_valid is high
//   rx_valid   : byte available, held until accepted
//   rx_ready   : consumer accepts when rx_valid & rx_ready at a rising edge
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overrun    : one-cycle pulse when a completed byte is dropped
// Timing: with t0 the first edge sampling rx_serial low, rx_valid rises on
// edge t0 + 2 + H + 9*C (2 synchronizer cycles, half bit, 8 data + stop).
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int unsigned BAUD_RATE   = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam uart_timing_t TIMING      = calc_timing(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned  BIT_CYCLES  = TIMING.bit_cycles;
    localparam int unsigned  HALF_CYCLES = TIMING.half_cycles;
    localparam int unsigned  CNT_W       = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    // Below four clocks per bit the half-bit point and the synchronizer delay
    // no longer leave a usable sampling window.
    if (BIT_CYCLES < 4) begin : g_bad_timing
        $fatal(1, "uart_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
    end

    logic             rxs;
    rx_state_t        state,     state_next;
    logic [CNT_W-1:0] cnt,       cnt_next;
    logic [2:0]       idx,       idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       rx_data_next;
    logic             rx_valid_next;
    logic             frame_err_next;
    logic             overrun_next;
    logic             deliver;
    logic             load;

    uart_rx_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_serial),
        .sync_out (rxs)
    );

    // State and datapath registers. Everything returns to idle on reset so a
    // frame interrupted by reset leaves no trace and produces no pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift_reg <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shift_reg <= shift_next;
            rx_data   <= rx_data_next;
            rx_valid  <= rx_valid_next;
            frame_err <= frame_err_next;
            overrun   <= overrun_next;
        end
    end

    // Receiver sequencing. The start bit is re-checked at its midpoint to
    // reject glitches; from then on every sample is taken one full bit later,
    // i.e. at the centre of each data bit and of the stop bit. A low stop bit
    // parks the FSM in BREAK so a held-low line reports only one frame error.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        idx_next       = idx;
        shift_next     = shift_reg;
        deliver        = 1'b0;
        frame_err_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end

            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        state_next = ST_DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next        = '0;
                    shift_next[idx] = rxs;
                    if (idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rxs) begin
                        deliver    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = ST_BREAK;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            ST_BREAK: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output holding register. A new byte may replace the held one only if
    // the slot is empty or is being accepted on this same edge; otherwise the
    // held byte wins and the new one is dropped with an overrun pulse.
    always_comb begin
        load          = deliver && (!rx_valid || rx_ready);
        overrun_next  = deliver && rx_valid && !rx_ready;
        rx_data_next  = rx_data;
        rx_valid_next = rx_valid;
        if (load) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at 1 MHz / 100 kBd (10 clocks per bit).
// A transaction-level model schedules, for each frame sent, what must appear
// on the outputs and on which edge; a compare process checks every output on
// every cycle, and directed tests pin the model with literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CLK_HZ  = 1_000_000;
    localparam int unsigned BAUD    = 100_000;
    localparam int unsigned C       = CLK_HZ / BAUD;
    localparam int unsigned H       = C / 2;
    localparam int unsigned LATENCY = 2 + H + 9 * C;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       rx_serial = 1'b1;
    logic       rx_ready  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    typedef struct {
        int unsigned edge_no;
        bit          is_err;
        logic [7:0]  data;
    } ev_t;

    ev_t         evq[$];
    ev_t         cur_ev;
    int unsigned edge_count = 0;
    bit          started    = 1'b0;
    logic [7:0]  exp_data   = 8'h00;
    bit          exp_valid  = 1'b0;
    bit          exp_fe     = 1'b0;
    bit          exp_ov     = 1'b0;
    bit          exp_load;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  got_q[$];
    int          fe_count   = 0;
    int          ov_count   = 0;
    int          rise_edge  = -1;
    bit          prev_valid = 1'b0;
    int unsigned t0;
    int unsigned t_unused;

    uart_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // 1 MHz clock.
    initial begin
        forever #500 clk = ~clk;
    end

    // Generic comparison: counts every check, reports each mismatch once.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at edge %0d",
                     name, actual, expected, edge_count);
        end
    endtask

    // Compares the n-th byte captured by the monitor with a literal.
    task automatic checkByte(input string name, input int n, input logic [7:0] expected);
        logic [31:0] actual;
        actual = 32'hxxxx_xxxx;
        if (n < got_q.size()) actual = {24'h0, got_q[n]};
        checkOutput(name, actual, {24'h0, expected});
    endtask

    task automatic clearMonitor();
        got_q.delete();
        fe_count  = 0;
        ov_count  = 0;
        rise_edge = -1;
    endtask

    // Sends one frame bit by bit, changing the line on falling edges, and
    // tells the model when the outcome of this frame is due.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_val,
                                 input int stop_cycles, input int gap_cycles,
                                 output int unsigned start_edge);
        ev_t ev;
        @(negedge clk);
        rx_serial  = 1'b0;
        start_edge = edge_count + 1;
        ev.edge_no = start_edge + LATENCY;
        ev.is_err  = !stop_val;
        ev.data    = b;
        evq.push_back(ev);
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (C) @(negedge clk);
        end
        rx_serial = stop_val;
        repeat (stop_cycles) @(negedge clk);
        rx_serial = 1'b1;
        repeat (gap_cycles) @(negedge clk);
    endtask

    // Transaction-level model: at each edge apply any scheduled frame outcome
    // and the consumer handshake to the expected holding-register contents.
    initial begin
        forever begin
            @(posedge clk);
            edge_count++;
            if (rst) begin
                started   = 1'b1;
                exp_data  = 8'h00;
                exp_valid = 1'b0;
                exp_fe    = 1'b0;
                exp_ov    = 1'b0;
                evq.delete();
            end else begin
                exp_fe   = 1'b0;
                exp_ov   = 1'b0;
                exp_load = 1'b0;
                if (evq.size() > 0 && evq[0].edge_no == edge_count) begin
                    cur_ev = evq.pop_front();
                    if (cur_ev.is_err) exp_fe = 1'b1;
                    else if (!exp_valid || rx_ready) exp_load = 1'b1;
                    else exp_ov = 1'b1;
                end
                if (exp_load) begin
                    exp_data  = cur_ev.data;
                    exp_valid = 1'b1;
                end else if (exp_valid && rx_ready) begin
                    exp_valid = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a small monitor that records
    // each newly presented byte and counts error pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                checkOutput("rx_valid",  {31'h0, rx_valid},  {31'h0, exp_valid});
                checkOutput("rx_data",   {24'h0, rx_data},   {24'h0, exp_data});
                checkOutput("frame_err", {31'h0, frame_err}, {31'h0, exp_fe});
                checkOutput("overrun",   {31'h0, overrun},   {31'h0, exp_ov});
                if (rx_valid && !prev_valid) begin
                    got_q.push_back(rx_data);
                    rise_edge = int'(edge_count);
                end
                if (frame_err) fe_count++;
                if (overrun) ov_count++;
                prev_valid = rx_valid;
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] msg [6];
        msg[0] = 8'h41; msg[1] = 8'h54; msg[2] = 8'h2B;
        msg[3] = 8'h58; msg[4] = 8'h0D; msg[5] = 8'h0A;

        // Reset state.
        repeat (4) @(negedge clk);
        checkOutput("reset rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("reset rx_data",  {24'h0, rx_data},  32'h0);
        checkOutput("reset frame_err", {31'h0, frame_err}, 32'h0);
        checkOutput("reset overrun",  {31'h0, overrun},  32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single byte and its exact latency.
        clearMonitor();
        applyStimulus(8'h41, 1'b1, C, 20, t0);
        checkOutput("0x41 count", got_q.size(), 32'd1);
        checkByte("0x41 byte", 0, 8'h41);
        checkOutput("0x41 latency", rise_edge - int'(t0), 32'd97);
        checkOutput("0x41 frame_err", fe_count, 32'd0);
        checkOutput("0x41 overrun", ov_count, 32'd0);

        // String with half-bit gaps.
        clearMonitor();
        for (int i = 0; i < 6; i++) applyStimulus(msg[i], 1'b1, C, H, t_unused);
        repeat (2 * C) @(negedge clk);
        checkOutput("string count", got_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) checkByte($sformatf("string byte %0d", i), i, msg[i]);
        checkOutput("string errors", fe_count + ov_count, 32'd0);

        // Backpressure: second byte dropped with one overrun pulse.
        clearMonitor();
        rx_ready = 1'b0;
        applyStimulus(8'h31, 1'b1, C, H, t_unused);
        applyStimulus(8'h32, 1'b1, C, 20, t_unused);
        checkOutput("overrun count", ov_count, 32'd1);
        checkOutput("overrun held valid", {31'h0, rx_valid}, 32'd1);
        checkOutput("overrun held data", {24'h0, rx_data}, 32'h31);
        checkOutput("overrun presented", got_q.size(), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        checkOutput("overrun accepted", {31'h0, rx_valid}, 32'd0);
        repeat (5) @(negedge clk);

        // Low stop bit followed by a held-low line, then recovery.
        clearMonitor();
        applyStimulus(8'h55, 1'b0, 3 * C, 2 * C, t_unused);
        checkOutput("break frame_err count", fe_count, 32'd1);
        checkOutput("break no byte", got_q.size(), 32'd0);
        clearMonitor();
        applyStimulus(8'h0D, 1'b1, C, 20, t_unused);
        checkOutput("after break count", got_q.size(), 32'd1);
        checkByte("after break byte", 0, 8'h0D);
        checkOutput("after break frame_err", fe_count, 32'd0);

        // Short glitch on the line.
        clearMonitor();
        @(negedge clk);
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        repeat (3 * C) @(negedge clk);
        checkOutput("glitch no byte", got_q.size(), 32'd0);
        checkOutput("glitch no frame_err", fe_count, 32'd0);

        // Reset in the middle of bit 4, then a clean frame.
        clearMonitor();
        fork
            applyStimulus(8'hA5, 1'b1, C, C, t_unused);
            begin
                repeat (53) @(negedge clk);
                rst = 1'b1;
                repeat (60) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (C) @(negedge clk);
        checkOutput("reset abort no byte", got_q.size(), 32'd0);
        checkOutput("reset abort no pulse", fe_count + ov_count, 32'd0);
        applyStimulus(8'h5A, 1'b1, C, 20, t_unused);
        checkOutput("post reset count", got_q.size(), 32'd1);
        checkByte("post reset byte", 0, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
